// File: rtl/shift_right_seq.sv
// Sequential 16-bit right shifter: one bit per clock, logical or arithmetic fill.
// The result appears in dout on entry to DONE and is held until the next completion.
module shift_right_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        arith,
  input  logic [3:0]  shamt,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic signed [15:0]  work;
  logic [3:0]          count;
  logic                mode;

  // Single-bit right shift; mode selects sign fill over zero fill.
  function automatic logic signed [15:0] shr1(input logic signed [15:0] v, input logic m);
    shr1 = {(m ? v[15] : 1'b0), v[15:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      mode  <= 1'b0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work  <= din;
            count <= shamt;
            mode  <= arith;
            if (shamt == 4'd0) begin
              dout  <= din;
              state <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work  <= shr1(work, mode);
          count <= count - 4'd1;
          // Last shift: publish the shifted value directly so dout never sees intermediates.
          if (count == 4'd1) begin
            dout  <= shr1(work, mode);
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Randomized scoreboard bench for shift_right_seq: driver queues expected results,
// a negedge monitor checks busy, done timing and the held dout value every cycle.
module tb_shift_right_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [3:0]  shamt;
  logic [15:0] din;
  logic        busy;
  logic        done;
  logic [15:0] dout;

  shift_right_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .arith (arith),
    .shamt (shamt),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  typedef struct {
    int          issue;
    int          n;
    logic [15:0] res;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_dout = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input int s, input logic a);
    logic signed [15:0] sd;
    sd = d;
    if (a) return 16'(sd >>> s);
    return d >> s;
  endfunction

  // Called at a negedge; returns at the negedge of relative cycle 1.
  task automatic issue(input logic [15:0] d, input logic [3:0] s, input logic a, input logic [15:0] e);
    exp_t t;
    t.issue = cyc;
    t.n     = int'(s);
    t.res   = e;
    start = 1'b1;
    din   = d;
    shamt = s;
    arith = a;
    @(posedge clk);
    q.push_back(t);
    @(negedge clk);
    start = 1'b0;
    din   = 16'($urandom);
    shamt = 4'($urandom);
    arith = 1'($urandom);
  endtask

  // Spend relative cycles 1..n+1 throwing ignored starts and noisy operands, end at cycle n+2.
  task automatic busy_wait(input int n, input bit noisy);
    for (int i = 0; i < n + 1; i++) begin
      @(negedge clk);
      if (noisy) begin
        start = 1'($urandom);
        din   = 16'($urandom);
        shamt = 4'($urandom);
        arith = 1'($urandom);
      end
    end
    start = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_dout = 16'h0000;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dout", {16'd0, dout}, 32'd0);
    end else begin
      logic exp_busy;
      logic exp_done;
      exp_busy = (q.size() > 0) && (cyc >= q[0].issue + 1);
      exp_done = (q.size() > 0) && (cyc == q[0].issue + q[0].n + 1);
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if ((q.size() > 0) && (cyc >= q[0].issue + q[0].n + 1)) begin
        exp_dout = q[0].res;
        void'(q.pop_front());
      end
      chk("dout", {16'd0, dout}, {16'd0, exp_dout});
    end
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  s;
    logic        a;
    rst_n = 1'b0;
    start = 1'b0;
    arith = 1'b0;
    shamt = 4'd0;
    din   = 16'h0000;
    #2;
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_done", {31'd0, done}, 32'd0);
    chk("init_dout", {16'd0, dout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(16'h0002, 4'd1, 1'b0, 16'h0001);
    busy_wait(1, 1'b0);
    issue(16'h8000, 4'd15, 1'b1, 16'hFFFF);
    busy_wait(15, 1'b0);
    issue(16'h8000, 4'd15, 1'b0, 16'h0001);
    busy_wait(15, 1'b0);
    issue(16'hFFFF, 4'd0, 1'b0, 16'hFFFF);
    busy_wait(0, 1'b0);
    @(negedge clk);

    // Ignored start in cycle 2, accepted back-to-back start in cycle 6
    issue(16'hF0F0, 4'd4, 1'b1, 16'hFF0F);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; din = 16'h1234; shamt = 4'd1; arith = 1'b0;
    repeat (4) @(negedge clk);
    issue(16'h1234, 4'd4, 1'b0, 16'h0123);
    busy_wait(4, 1'b1);

    // Reset in cycle 3 of a shamt=8 operation
    issue(16'hABCD, 4'd8, 1'b1, model(16'hABCD, 8, 1'b1));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_done", {31'd0, done}, 32'd0);
    chk("async_dout", {16'd0, dout}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(16'h0100, 4'd8, 1'b0, 16'h0001);
    busy_wait(8, 1'b1);

    // Random operations
    for (int k = 0; k < 1000; k++) begin
      d = 16'($urandom);
      s = 4'($urandom);
      a = 1'($urandom);
      if (k % 8 == 0) s = 4'd15;
      if (k % 8 == 1) s = 4'd0;
      issue(d, s, a, model(d, int'(s), a));
      busy_wait(int'(s), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
